dma_sysid_check_ctrl: RTL and testbench

Avalon-MM read master that sequences the system-ID control slave in the DMA memory subsystem. It reads the ID word at address 0 and the timestamp word at address 1, then compares both against build-time expected values. It reports pass/fail, mismatch and timeout status, which host-side logic uses to gate DMA enable. It retries on bus timeout and runs automatically once after reset, or on request.

---
 rtl/dma_mem_pkg.sv | 21 ++
 rtl/dma_sysid_check_ctrl.sv | 152 +++++++++++++++
 tb/tb_dma_sysid_check_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_mem_pkg.sv
// Shared definitions for the DMA memory subsystem: sysid checker FSM states,
// sysid register map and the default build-time identity values.
`timescale 1ns/1ps
package dma_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_CHECK,
    ST_GAP,
    ST_DONE
  } sysid_state_t;

  localparam logic        ADDR_ID = 1'b0;
  localparam logic        ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1472780459;

endpackage

// File: rtl/dma_sysid_check_ctrl.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words,
// compares them with build-time values and reports pass/mismatch/timeout.
`timescale 1ns/1ps
module dma_sysid_check_ctrl
  import dma_mem_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned AUTO_START     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  sysid_state_t  state, state_next;
  logic [CW-1:0] to_cnt;
  logic [RW-1:0] retry_cnt;
  logic          pending;

  logic launch;
  logic cap_id;
  logic cap_ts;
  logic stall_last;
  logic abort;
  logic can_retry;

  assign stall_last = avm_waitrequest && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign can_retry  = (retry_cnt < RW'(MAX_RETRIES));

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    abort       = 1'b0;
    avm_read    = 1'b0;
    avm_address = ADDR_ID;
    done        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start || pending) begin
          launch     = 1'b1;
          state_next = ST_RD_ID;
        end
      end
      ST_RD_ID: begin
        avm_read    = 1'b1;
        avm_address = ADDR_ID;
        if (!avm_waitrequest) begin
          cap_id     = 1'b1;
          state_next = ST_RD_TS;
        end else if (stall_last) begin
          abort      = 1'b1;
          state_next = can_retry ? ST_GAP : ST_DONE;
        end
      end
      ST_RD_TS: begin
        avm_read    = 1'b1;
        avm_address = ADDR_TS;
        if (!avm_waitrequest) begin
          cap_ts     = 1'b1;
          state_next = ST_CHECK;
        end else if (stall_last) begin
          abort      = 1'b1;
          state_next = can_retry ? ST_GAP : ST_DONE;
        end
      end
      ST_CHECK: state_next = ST_DONE;
      ST_GAP:   state_next = ST_RD_ID;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending     <= (AUTO_START != 0);
      busy        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      to_cnt      <= '0;
      retry_cnt   <= '0;
    end else begin
      if (launch) begin
        pending     <= 1'b0;
        busy        <= 1'b1;
        pass        <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        timeout     <= 1'b0;
      end

      // Counter only advances on stalled read cycles; any completion or abort rearms it.
      if ((state == ST_RD_ID || state == ST_RD_TS) && avm_waitrequest && !abort)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;

      if (cap_id) id_value <= avm_readdata;
      if (cap_ts) ts_value <= avm_readdata;

      if (abort) begin
        if (can_retry) begin
          retry_cnt <= retry_cnt + 1'b1;
        end else begin
          timeout <= 1'b1;
          pass    <= 1'b0;
        end
      end

      if (state == ST_CHECK) begin
        id_mismatch <= (id_value != EXPECTED_ID);
        ts_mismatch <= (ts_value != EXPECTED_TS);
        pass        <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
      end

      if (state != ST_DONE && state_next == ST_DONE) busy <= 1'b0;
      if (state == ST_DONE) retry_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dma_sysid_check_ctrl.sv
// Directed bench for dma_sysid_check_ctrl: default instance for normal runs,
// a short-timeout instance for the retry/timeout sequence.
`timescale 1ns/1ps
module tb_dma_sysid_check_ctrl;
  import dma_mem_pkg::*;

  localparam logic [31:0] TS_GOOD = 32'd1472780459;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  logic        reset_to = 1'b1;
  logic        start_to = 1'b0;
  logic        wr_to    = 1'b1;
  logic        addr_to, read_to;
  logic        busy_to, done_to, pass_to, id_mm_to, ts_mm_to, timeout_to;
  logic [31:0] id_val_to, ts_val_to;

  logic [31:0] slave_id = 32'd0;
  logic [31:0] slave_ts = TS_GOOD;
  logic        wr_main  = 1'b0;
  bit          id_stall = 1'b0;
  int          ts_stall_left = 0;
  int          hold_viol = 0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  assign avm_readdata    = avm_address ? slave_ts : slave_id;
  assign avm_waitrequest = wr_main;

  dma_sysid_check_ctrl dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .pass(pass),
    .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  dma_sysid_check_ctrl #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(2)) dut_to (
    .clock(clock), .reset(reset_to), .start(start_to),
    .avm_address(addr_to), .avm_read(read_to),
    .avm_readdata(32'd0), .avm_waitrequest(wr_to),
    .busy(busy_to), .done(done_to), .pass(pass_to),
    .id_mismatch(id_mm_to), .ts_mismatch(ts_mm_to), .timeout(timeout_to),
    .id_value(id_val_to), .ts_value(ts_val_to)
  );

  // Passive event counters, read as before/after deltas.
  int done_cnt = 0, rd_cnt = 0, busy_cnt = 0;
  int done_cnt_to = 0, rd_cnt_to = 0, rise_to = 0, gap_to = 0, addr1_to = 0;
  logic prev_read_to = 1'b0;

  always @(negedge clock) begin
    if (done === 1'b1) done_cnt++;
    if (avm_read === 1'b1) rd_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (done_to === 1'b1) done_cnt_to++;
    if (read_to === 1'b1) rd_cnt_to++;
    if (read_to === 1'b1 && prev_read_to !== 1'b1) rise_to++;
    if (busy_to === 1'b1 && read_to === 1'b0) gap_to++;
    if (read_to === 1'b1 && addr_to === 1'b1) addr1_to++;
    prev_read_to <= read_to;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_slave();
    if (wr_main && !(avm_read && avm_address == (id_stall ? ADDR_ID : ADDR_TS))) hold_viol++;
    wr_main = avm_read && ((id_stall && avm_address == ADDR_ID) ||
                           (avm_address == ADDR_TS && ts_stall_left > 0));
    if (wr_main && avm_address == ADDR_TS) ts_stall_left--;
  endtask

  task automatic wait_done(input bit use_to, input int limit, output int n);
    n = 0;
    while (n < limit && !((use_to ? done_to : done) === 1'b1)) begin
      tick();
      start = 1'b0;
      drive_slave();
      n++;
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_busy"},  busy, 0);
    check_eq({pfx, "_done"},  done, 0);
    check_eq({pfx, "_pass"},  pass, 0);
    check_eq({pfx, "_idmm"},  id_mismatch, 0);
    check_eq({pfx, "_tsmm"},  ts_mismatch, 0);
    check_eq({pfx, "_tmo"},   timeout, 0);
    check_eq({pfx, "_read"},  avm_read, 0);
    check_eq({pfx, "_addr"},  avm_address, 0);
    check_eq({pfx, "_idval"}, id_value, 0);
    check_eq({pfx, "_tsval"}, ts_value, 0);
  endtask

  initial begin
    int n, d0, r0, b0;

    // Reset values
    repeat (3) tick();
    check_reset_state("rst");

    // Auto run against a matching slave
    d0 = done_cnt; b0 = busy_cnt;
    reset = 1'b0;
    wait_done(0, 20, n);
    check_eq("auto_lat", n, 4);
    check_eq("auto_pass", pass, 1);
    check_eq("auto_idmm", id_mismatch, 0);
    check_eq("auto_tsmm", ts_mismatch, 0);
    check_eq("auto_busy_done", busy, 0);
    check_eq("auto_tsval", ts_value, TS_GOOD);
    tick(); drive_slave();
    check_eq("auto_busy_cycles", busy_cnt - b0, 3);
    check_eq("auto_done_pulse", done, 0);
    check_eq("auto_pass_held", pass, 1);
    check_eq("auto_done_cnt", done_cnt - d0, 1);

    // ID mismatch, no retry
    slave_id = 32'h0000_0001;
    r0 = rd_cnt;
    start = 1'b1;
    tick(); start = 1'b0; drive_slave();
    check_eq("idmm_launch_pass_clr", pass, 0);
    check_eq("idmm_busy", busy, 1);
    wait_done(0, 20, n);
    check_eq("idmm_lat", n + 1, 4);
    check_eq("idmm_flag", id_mismatch, 1);
    check_eq("idmm_tsflag", ts_mismatch, 0);
    check_eq("idmm_pass", pass, 0);
    check_eq("idmm_idval", id_value, 32'h1);
    check_eq("idmm_reads", rd_cnt - r0, 2);
    slave_id = 32'd0;
    tick(); drive_slave();

    // 10-cycle stall on the timestamp read
    ts_stall_left = 10; hold_viol = 0;
    start = 1'b1;
    wait_done(0, 40, n);
    check_eq("stall_lat", n, 14);
    check_eq("stall_used", ts_stall_left, 0);
    check_eq("stall_hold", hold_viol, 0);
    check_eq("stall_pass", pass, 1);
    check_eq("stall_tmo", timeout, 0);
    check_eq("stall_tsval", ts_value, TS_GOOD);
    tick(); drive_slave();

    // start during RD_TS is dropped; later start runs again
    d0 = done_cnt;
    start = 1'b1;
    tick(); start = 1'b0; drive_slave();
    tick(); drive_slave();
    check_eq("drop_in_rdts", avm_address, 1);
    start = 1'b1;
    wait_done(0, 20, n);
    check_eq("drop_lat", n, 2);
    repeat (4) begin tick(); drive_slave(); end
    check_eq("drop_busy", busy, 0);
    check_eq("drop_one_done", done_cnt - d0, 1);
    start = 1'b1;
    wait_done(0, 20, n);
    check_eq("second_lat", n, 4);
    check_eq("second_pass", pass, 1);
    tick(); drive_slave();
    check_eq("second_done_cnt", done_cnt - d0, 2);

    // Reset during an ID stall, then auto run merged with start
    id_stall = 1'b1;
    start = 1'b1;
    tick(); start = 1'b0; drive_slave();
    tick(); drive_slave();
    tick(); drive_slave();
    check_eq("rstmid_read", avm_read, 1);
    check_eq("rstmid_wait", avm_waitrequest, 1);
    reset = 1'b1;
    tick(); id_stall = 1'b0; drive_slave();
    check_reset_state("rstmid");
    d0 = done_cnt;
    reset = 1'b0;
    start = 1'b1;
    tick(); start = 1'b0; drive_slave();
    check_eq("rearm_busy", busy, 1);
    check_eq("rearm_read", avm_read, 1);
    wait_done(0, 20, n);
    check_eq("rearm_lat", n + 1, 4);
    check_eq("rearm_pass", pass, 1);
    repeat (5) begin tick(); drive_slave(); end
    check_eq("merge_one_done", done_cnt - d0, 1);
    check_eq("merge_idle", busy, 0);

    // Stuck waitrequest, TIMEOUT_CYCLES=8, MAX_RETRIES=2
    reset_to = 1'b0;
    wait_done(1, 60, n);
    check_eq("tmo_lat", n, 27);
    check_eq("tmo_flag", timeout_to, 1);
    check_eq("tmo_pass", pass_to, 0);
    check_eq("tmo_busy", busy_to, 0);
    check_eq("tmo_idmm", id_mm_to, 0);
    tick();
    check_eq("tmo_attempts", rise_to, 3);
    check_eq("tmo_read_cycles", rd_cnt_to, 24);
    check_eq("tmo_gaps", gap_to, 2);
    check_eq("tmo_addr1", addr1_to, 0);
    check_eq("tmo_done_cnt", done_cnt_to, 1);
    check_eq("tmo_held", timeout_to, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
